// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor
// Three-stage per-pixel renderer: tile background, NUM_SPRITES prioritised
// sprite channels with transparency and blink, and a lives-heart HUD.
// Sprite/HUD state is captured into shadow registers at frame_start so a
// frame never shows a half-updated scene. Sprite-0 collision flags are
// accumulated per frame and published at the next frame_start.
module vga_sprite_compositor #(
  parameter int NUM_SPRITES   = 4,
  parameter int SPRITE_W      = 40,
  parameter int SPRITE_H      = 40,
  parameter int BLOCK_WIDTH   = 40,
  parameter int TILE_COLS     = 16,
  parameter int TILE_ROWS     = 12,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int MAX_LIVES     = 5,
  parameter int BLINK_BIT     = 3
) (
  input  logic                             vga_clock,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic [9:0]                       row,
  input  logic [9:0]                       column,
  input  logic                             display_enable,
  input  logic [TILE_ROWS*TILE_COLS*3-1:0] background,
  input  logic [NUM_SPRITES*10-1:0]        sprite_x,
  input  logic [NUM_SPRITES*10-1:0]        sprite_y,
  input  logic [NUM_SPRITES*12-1:0]        sprite_color,
  input  logic [NUM_SPRITES-1:0]           sprite_enable,
  input  logic [NUM_SPRITES-1:0]           sprite_blink,
  input  logic [2:0]                       lives,
  input  logic                             show_hearts,
  output logic [3:0]                       vga_red,
  output logic [3:0]                       vga_green,
  output logic [3:0]                       vga_blue,
  output logic [NUM_SPRITES-1:0]           collision,
  output logic [7:0]                       frame_count
);

  // Tile coordinates must hold column/BLOCK_WIDTH for any 10-bit column so
  // off-screen pixels can be recognised rather than aliased onto the map.
  localparam int TC_W      = $clog2((1024 / BLOCK_WIDTH) + 1);
  localparam int NUM_TILES = TILE_ROWS * TILE_COLS;

  localparam logic [11:0] RGB_BDR   = 12'h000;
  localparam logic [11:0] RGB_SKY   = 12'h5AF;
  localparam logic [11:0] RGB_BLK   = 12'hA52;
  localparam logic [11:0] RGB_GND   = 12'h6A3;
  localparam logic [11:0] RGB_TKN   = 12'hFD0;
  localparam logic [11:0] RGB_HEART = 12'hF00;

  function automatic logic [11:0] tile_rgb(input logic [2:0] code);
    case (code)
      3'd0:    tile_rgb = RGB_BDR;
      3'd2:    tile_rgb = RGB_BLK;
      3'd3:    tile_rgb = RGB_GND;
      3'd4:    tile_rgb = RGB_TKN;
      default: tile_rgb = RGB_SKY;
    endcase
  endfunction

  function automatic logic [2:0] sat_lives(input logic [2:0] l);
    if (int'(l) > MAX_LIVES) sat_lives = 3'(MAX_LIVES);
    else                     sat_lives = l;
  endfunction

  // Per-frame shadow state
  logic [NUM_SPRITES*10-1:0] sh_x;
  logic [NUM_SPRITES*10-1:0] sh_y;
  logic [NUM_SPRITES*12-1:0] sh_color;
  logic [NUM_SPRITES-1:0]    sh_en;
  logic [NUM_SPRITES-1:0]    sh_blink;
  logic [2:0]                sh_lives;
  logic                      sh_hearts;

  // Pipeline state
  logic [9:0]             row_p0;
  logic [9:0]             col_p0;
  logic [TC_W-1:0]        trow_p0;
  logic [TC_W-1:0]        tcol_p0;
  logic                   vld_p0;
  logic [NUM_SPRITES-1:0] hit_p1;
  logic                   heart_p1;
  logic [2:0]             tile_p1;
  logic                   oob_p1;
  logic                   vld_p1;
  logic [11:0]            rgb_p2;

  // Combinational stage results
  logic [NUM_SPRITES-1:0] hit_c;
  logic                   heart_c;
  logic [2:0]             tile_c;
  logic                   oob_c;
  int                     tile_idx;
  logic [11:0]            spr_rgb;
  logic [11:0]            pix_c;
  logic [NUM_SPRITES-1:0] coll_new;
  logic [NUM_SPRITES-1:0] coll_work;

  // Frame boundary: latch scene state and advance the frame counter
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      sh_x        <= '0;
      sh_y        <= '0;
      sh_color    <= '0;
      sh_en       <= '0;
      sh_blink    <= '0;
      sh_lives    <= '0;
      sh_hearts   <= 1'b0;
      frame_count <= 8'd0;
    end else if (frame_start) begin
      sh_x        <= sprite_x;
      sh_y        <= sprite_y;
      sh_color    <= sprite_color;
      sh_en       <= sprite_enable;
      sh_blink    <= sprite_blink;
      sh_lives    <= sat_lives(lives);
      sh_hearts   <= show_hearts;
      frame_count <= frame_count + 8'd1;
    end
  end

  // ---- Stage 1: register pixel coordinates and derive tile coordinates ----
  always_ff @(posedge vga_clock) begin
    row_p0  <= row;
    col_p0  <= column;
    trow_p0 <= TC_W'(row / BLOCK_WIDTH);
    tcol_p0 <= TC_W'(column / BLOCK_WIDTH);
  end

  // Valid travels with the pixel; cleared on reset so no partial pixels leak
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= display_enable;
      vld_p1 <= vld_p0;
    end
  end

  // ---- Stage 2: sprite hits, heart hit, tile lookup ----
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      hit_c[i] = sh_en[i]
              && (sh_color[12*i +: 12] != 12'h000)
              && !(sh_blink[i] && frame_count[BLINK_BIT])
              && ({1'b0, col_p0} >= {1'b0, sh_x[10*i +: 10]})
              && ({1'b0, col_p0} <  ({1'b0, sh_x[10*i +: 10]} + 11'(SPRITE_W)))
              && ({1'b0, row_p0} >= {1'b0, sh_y[10*i +: 10]})
              && ({1'b0, row_p0} <  ({1'b0, sh_y[10*i +: 10]} + 11'(SPRITE_H)));
    end

    heart_c = 1'b0;
    for (int k = 0; k < MAX_LIVES; k++) begin
      if ((k < int'(sh_lives))
          && (int'(col_p0) >= 4 + 20 * k)
          && (int'(col_p0) <= 19 + 20 * k)) begin
        heart_c = 1'b1;
      end
    end
    heart_c = heart_c && sh_hearts && (row_p0 >= 10'd4) && (row_p0 <= 10'd19);

    tile_c   = 3'd0;
    tile_idx = int'(trow_p0) * TILE_COLS + int'(tcol_p0);
    if ((int'(tcol_p0) < TILE_COLS) && (int'(trow_p0) < TILE_ROWS)) begin
      for (int t = 0; t < NUM_TILES; t++) begin
        if (t == tile_idx) tile_c = background[3*t +: 3];
      end
    end

    oob_c = (int'(col_p0) >= SCREEN_WIDTH) || (int'(row_p0) >= SCREEN_HEIGHT);
  end

  always_ff @(posedge vga_clock) begin
    hit_p1   <= hit_c;
    heart_p1 <= heart_c;
    tile_p1  <= tile_c;
    oob_p1   <= oob_c;
  end

  // ---- Stage 3: priority mux, collision detect, output register ----
  always_comb begin
    spr_rgb = 12'h000;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_p1[i]) spr_rgb = sh_color[12*i +: 12];
    end

    pix_c = 12'h000;
    if (vld_p1) begin
      if (oob_p1)        pix_c = RGB_BDR;
      else if (heart_p1) pix_c = RGB_HEART;
      else if (|hit_p1)  pix_c = spr_rgb;
      else               pix_c = tile_rgb(tile_p1);
    end

    coll_new = '0;
    if (vld_p1 && hit_p1[0]) coll_new = {hit_p1[NUM_SPRITES-1:1], 1'b0};
  end

  always_ff @(posedge vga_clock) begin
    if (reset) rgb_p2 <= 12'h000;
    else       rgb_p2 <= pix_c;
  end

  // A pixel landing on frame_start belongs to the frame that is starting
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      coll_work <= '0;
      collision <= '0;
    end else begin
      if (frame_start) collision <= coll_work;
      coll_work <= (frame_start ? '0 : coll_work) | coll_new;
    end
  end

  assign vga_red   = rgb_p2[11:8];
  assign vga_green = rgb_p2[7:4];
  assign vga_blue  = rgb_p2[3:0];

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor: background, sprites, priority,
// shadowing, blink, hearts, collision and mid-frame reset.
module tb_vga_sprite_compositor;

  localparam int NS = 4;

  logic          vga_clock = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [9:0]    row;
  logic [9:0]    column;
  logic          display_enable;
  logic [575:0]  background;
  logic [NS*10-1:0] sprite_x;
  logic [NS*10-1:0] sprite_y;
  logic [NS*12-1:0] sprite_color;
  logic [NS-1:0] sprite_enable;
  logic [NS-1:0] sprite_blink;
  logic [2:0]    lives;
  logic          show_hearts;
  logic [3:0]    vga_red;
  logic [3:0]    vga_green;
  logic [3:0]    vga_blue;
  logic [NS-1:0] collision;
  logic [7:0]    frame_count;
  logic [11:0]   rgb;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_fc = 0;

  vga_sprite_compositor dut (
    .vga_clock      (vga_clock),
    .reset          (reset),
    .frame_start    (frame_start),
    .row            (row),
    .column         (column),
    .display_enable (display_enable),
    .background     (background),
    .sprite_x       (sprite_x),
    .sprite_y       (sprite_y),
    .sprite_color   (sprite_color),
    .sprite_enable  (sprite_enable),
    .sprite_blink   (sprite_blink),
    .lives          (lives),
    .show_hearts    (show_hearts),
    .vga_red        (vga_red),
    .vga_green      (vga_green),
    .vga_blue       (vga_blue),
    .collision      (collision),
    .frame_count    (frame_count)
  );

  assign rgb = {vga_red, vga_green, vga_blue};

  always #5 vga_clock = ~vga_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_spr(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic [11:0] c, input logic en, input logic bl);
    sprite_x[10*i +: 10]     = x;
    sprite_y[10*i +: 10]     = y;
    sprite_color[12*i +: 12] = c;
    sprite_enable[i]         = en;
    sprite_blink[i]          = bl;
  endtask

  // Drain the pipeline with blanking, then pulse frame_start for one cycle
  task automatic frame();
    @(negedge vga_clock);
    display_enable = 1'b0;
    repeat (4) @(negedge vga_clock);
    frame_start = 1'b1;
    @(negedge vga_clock);
    frame_start = 1'b0;
    exp_fc = (exp_fc + 1) % 256;
  endtask

  // Present one active pixel and check the colour three clocks later
  task automatic probe(input string tag, input logic [9:0] r, input logic [9:0] c,
                       input logic [11:0] exp);
    @(negedge vga_clock);
    row = r;
    column = c;
    display_enable = 1'b1;
    repeat (3) @(posedge vga_clock);
    #1;
    check(tag, rgb, exp);
    @(negedge vga_clock);
    display_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    row = '0;
    column = '0;
    display_enable = 1'b0;
    background = {192{3'b001}};
    sprite_x = '0;
    sprite_y = '0;
    sprite_color = '0;
    sprite_enable = '0;
    sprite_blink = '0;
    lives = 3'd0;
    show_hearts = 1'b0;

    // Reset state
    repeat (3) @(posedge vga_clock);
    @(negedge vga_clock);
    reset = 1'b0;
    @(posedge vga_clock);
    #1;
    check("reset_rgb", rgb, 12'h000);
    check("reset_coll", collision, 4'b0000);
    check("reset_fc", frame_count, 8'd0);

    // Background only, latency exactly three cycles
    frame();
    check("fc_1", frame_count, exp_fc);
    @(negedge vga_clock);
    row = 10'd50;
    column = 10'd100;
    display_enable = 1'b1;
    repeat (2) @(posedge vga_clock);
    #1;
    check("latency_2", rgb, 12'h000);
    @(posedge vga_clock);
    #1;
    check("latency_3_sky", rgb, 12'h5AF);
    @(negedge vga_clock);
    display_enable = 1'b0;
    repeat (3) @(posedge vga_clock);
    #1;
    check("de0_black", rgb, 12'h000);

    // Tile palette and off-screen border
    background[3*2 +: 3]   = 3'd2;
    background[3*19 +: 3]  = 3'd4;
    background[3*20 +: 3]  = 3'd6;
    background[3*21 +: 3]  = 3'd0;
    background[3*191 +: 3] = 3'd3;
    probe("tile_blk", 10'd10, 10'd85, 12'hA52);
    probe("tile_tkn", 10'd45, 10'd125, 12'hFD0);
    probe("tile_6_sky", 10'd45, 10'd165, 12'h5AF);
    probe("tile_bdr", 10'd45, 10'd205, 12'h000);
    probe("tile_gnd_last", 10'd470, 10'd630, 12'h6A3);
    probe("oob_col", 10'd50, 10'd700, 12'h000);
    probe("oob_row", 10'd500, 10'd100, 12'h000);
    background = {192{3'b001}};

    // Sprite priority, transparency, edges; collision 0 then 1
    set_spr(0, 10'd80, 10'd40, 12'h0F0, 1'b1, 1'b0);
    set_spr(1, 10'd90, 10'd40, 12'h00F, 1'b1, 1'b0);
    set_spr(2, 10'd80, 10'd40, 12'h000, 1'b1, 1'b0);
    set_spr(3, 10'd85, 10'd40, 12'hF0F, 1'b0, 1'b0);
    frame();
    check("fc_2", frame_count, exp_fc);
    probe("spr_overlap", 10'd50, 10'd95, 12'h0F0);
    probe("spr0_right_edge", 10'd50, 10'd119, 12'h0F0);
    probe("spr1_only", 10'd50, 10'd125, 12'h00F);
    probe("spr1_right_edge", 10'd50, 10'd129, 12'h00F);
    probe("past_spr1", 10'd50, 10'd130, 12'h5AF);
    probe("spr0_bottom_edge", 10'd79, 10'd82, 12'h0F0);
    probe("below_spr0", 10'd80, 10'd82, 12'h5AF);
    probe("disabled_spr3", 10'd50, 10'd86, 12'h0F0);
    check("coll_prev_frame", collision, 4'b0000);
    frame();
    check("coll_frame2", collision, 4'b0010);

    // Mid-frame change is held back until frame_start
    sprite_x[9:0] = 10'd300;
    probe("shadow_hold_old", 10'd50, 10'd95, 12'h0F0);
    probe("shadow_hold_new", 10'd50, 10'd310, 12'h5AF);
    frame();
    check("coll_frame3", collision, 4'b0010);
    probe("shadow_loaded_old", 10'd50, 10'd95, 12'h00F);
    probe("shadow_loaded_new", 10'd50, 10'd310, 12'h0F0);
    frame();
    check("coll_frame4_none", collision, 4'b0000);

    // Blink on frame_count bit 3, and blanked sprites do not collide
    set_spr(0, 10'd300, 10'd40, 12'h0F0, 1'b1, 1'b1);
    set_spr(1, 10'd300, 10'd40, 12'h00F, 1'b1, 1'b0);
    frame();
    check("fc_6", frame_count, 8'd6);
    probe("blink_fc6_visible", 10'd50, 10'd310, 12'h0F0);
    frame();
    check("coll_blink_visible", collision, 4'b0010);
    frame();
    check("fc_8", frame_count, 8'd8);
    probe("blink_fc8_hidden", 10'd50, 10'd310, 12'h00F);
    frame();
    check("coll_blink_hidden", collision, 4'b0000);
    while (exp_fc != 15) frame();
    probe("blink_fc15_hidden", 10'd50, 10'd310, 12'h00F);
    frame();
    probe("blink_fc16_visible", 10'd50, 10'd310, 12'h0F0);
    while (exp_fc != 255) frame();
    check("fc_255", frame_count, 8'd255);
    frame();
    check("fc_wrap_0", frame_count, 8'd0);
    probe("blink_fc0_visible", 10'd50, 10'd310, 12'h0F0);

    // Hearts: saturation, geometry, priority over sprites, HUD enable
    set_spr(0, 10'd0, 10'd0, 12'h0F0, 1'b1, 1'b0);
    set_spr(1, 10'd0, 10'd0, 12'h00F, 1'b0, 1'b0);
    set_spr(2, 10'd0, 10'd0, 12'h000, 1'b0, 1'b0);
    lives = 3'd7;
    show_hearts = 1'b1;
    frame();
    probe("heart4", 10'd10, 10'd85, 12'hF00);
    probe("heart5_absent", 10'd10, 10'd105, 12'h5AF);
    probe("heart0_over_spr", 10'd10, 10'd4, 12'hF00);
    probe("heart_gap_spr", 10'd10, 10'd20, 12'h0F0);
    probe("heart_row3", 10'd3, 10'd10, 12'h0F0);
    probe("heart_row19", 10'd19, 10'd10, 12'hF00);
    probe("heart_row20", 10'd20, 10'd10, 12'h0F0);
    lives = 3'd2;
    frame();
    probe("lives2_heart1", 10'd10, 10'd25, 12'hF00);
    probe("lives2_heart2_absent", 10'd10, 10'd45, 12'h5AF);
    show_hearts = 1'b0;
    frame();
    probe("hud_off_spr", 10'd10, 10'd10, 12'h0F0);
    probe("hud_off_bg", 10'd10, 10'd85, 12'h5AF);

    // Reset mid-frame while a sprite is on screen
    set_spr(1, 10'd0, 10'd0, 12'h00F, 1'b1, 1'b0);
    frame();
    probe("pre_reset_overlap", 10'd10, 10'd10, 12'h0F0);
    frame();
    check("pre_reset_coll", collision, 4'b0010);
    @(negedge vga_clock);
    row = 10'd10;
    column = 10'd10;
    display_enable = 1'b1;
    repeat (3) @(posedge vga_clock);
    #1;
    check("pre_reset_rgb", rgb, 12'h0F0);
    @(negedge vga_clock);
    reset = 1'b1;
    @(posedge vga_clock);
    #1;
    check("mid_reset_rgb", rgb, 12'h000);
    check("mid_reset_coll", collision, 4'b0000);
    check("mid_reset_fc", frame_count, 8'd0);
    exp_fc = 0;
    @(negedge vga_clock);
    reset = 1'b0;
    repeat (4) @(posedge vga_clock);
    #1;
    check("post_reset_bg_only", rgb, 12'h5AF);
    frame();
    check("post_reset_fc", frame_count, exp_fc);
    probe("post_reset_spr_back", 10'd10, 10'd10, 12'h0F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
